// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Data wins ties; a starvation counter forces a waiting fetch through after STARVE_LIMIT data grants.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_done,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        starve_q, starve_d;
  logic              grant_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      starve_q   <= 4'd0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      starve_q   <= starve_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    starve_d   = starve_q;
    // Data belongs to the older instruction, so it wins unless fetch has lost LIMIT times in a row.
    grant_data = d_req && !(if_req && (starve_q == LIMIT));
    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          owner_d  = grant_data;
          we_d     = grant_data && d_we;
          addr_d   = grant_data ? d_addr : if_addr;
          wdata_d  = grant_data ? d_wdata : '0;
          starve_d = (grant_data && if_req) ? starve_q + 4'd1 : 4'd0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          if (!owner_q)   if_rdata_d = mem_rdata;
          else if (!we_q) d_rdata_d  = mem_rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_valid = (state_q == BUSY);
  assign mem_we    = mem_valid && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != IDLE);
  assign if_done   = (state_q == DONE) && !owner_q;
  assign d_done    = (state_q == DONE) && owner_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_stall  = if_req && !if_done;
  assign d_stall   = d_req && !d_done;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model
// that predicts grant order, backend timing and returned data.
module tb_mem_port_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_done, if_stall, d_done, d_stall;
  logic [31:0] if_rdata, d_rdata;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic        mem_valid, mem_we, busy;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state
  int          cyc = 0;
  int          grant_cyc = -10, ready_cyc = -10, done_cyc = -10, m_free = 0, streak = 0;
  logic        exp_owner = 1'b0, exp_we = 1'b0;
  logic [31:0] exp_addr = '0, exp_wdata = '0, exp_rd = '0;
  logic [31:0] exp_if_rdata = '0, exp_d_rdata = '0;
  logic [31:0] bmem [16];
  int          next_k = 0;
  bit          spurious = 1'b0, force_ready = 1'b0;

  // Observations of the DUT
  int          vcnt = 0, last_if_done = -1, last_d_done = -1, if_done_cnt = 0, d_done_cnt = 0;
  logic        if_stall_at_done = 1'b1;
  bit          obs_log[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    bit dwin, in_busy, exp_busy, exp_ifd, exp_dd;
    int k;
    if (!reset && cyc >= m_free && (if_req || d_req)) begin
      dwin      = d_req && !(if_req && streak == LIMIT);
      streak    = (dwin && if_req) ? streak + 1 : 0;
      k         = (next_k >= 0) ? next_k : int'($urandom_range(0, 3));
      grant_cyc = cyc;
      ready_cyc = cyc + 1 + k;
      done_cyc  = cyc + 2 + k;
      m_free    = cyc + 3 + k;
      exp_owner = dwin;
      exp_we    = dwin && d_we;
      exp_addr  = dwin ? d_addr : if_addr;
      exp_wdata = d_wdata;
      if (exp_we) bmem[exp_addr[3:0]] = d_wdata;
      else        exp_rd = bmem[exp_addr[3:0]];
    end
    in_busy  = (cyc > grant_cyc) && (cyc < done_cyc);
    exp_busy = (cyc > grant_cyc) && (cyc <= done_cyc);
    if (cyc == ready_cyc) begin
      mem_ready = 1'b1;
      mem_rdata = exp_we ? $urandom : exp_rd;
    end else begin
      mem_ready = force_ready || (!in_busy && spurious && $urandom_range(0, 3) == 0);
      mem_rdata = $urandom;
    end
    if (cyc == done_cyc) begin
      if (!exp_owner)   exp_if_rdata = exp_rd;
      else if (!exp_we) exp_d_rdata  = exp_rd;
    end
    exp_ifd = (cyc == done_cyc) && !exp_owner;
    exp_dd  = (cyc == done_cyc) && exp_owner;
    @(negedge clk);
    check("mem_valid", mem_valid, in_busy);
    check("busy", busy, exp_busy);
    check("if_done", if_done, exp_ifd);
    check("d_done", d_done, exp_dd);
    check("if_stall", if_stall, if_req && !exp_ifd);
    check("d_stall", d_stall, d_req && !exp_dd);
    check("if_rdata", if_rdata, exp_if_rdata);
    check("d_rdata", d_rdata, exp_d_rdata);
    if (in_busy) begin
      check("mem_addr", mem_addr, exp_addr);
      check("mem_we", mem_we, exp_we);
      if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
    end
    if (mem_valid) vcnt++;
    if (if_done) begin
      last_if_done = cyc; if_done_cnt++; if_stall_at_done = if_stall; obs_log.push_back(1'b0);
    end
    if (d_done) begin
      last_d_done = cyc; d_done_cnt++; obs_log.push_back(1'b1);
    end
    if (reset) begin
      grant_cyc = -10; ready_cyc = -10; done_cyc = -10; m_free = cyc + 1; streak = 0;
      exp_if_rdata = '0; exp_d_rdata = '0;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int t, cnt0;
    for (int i = 0; i < 16; i++) bmem[i] = $urandom;

    // Reset values
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    check("rst_mem_valid", mem_valid, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_if_done", if_done, 1'b0);
    check("rst_d_done", d_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle: spurious mem_ready with no requests
    force_ready = 1'b1; cycle(); force_ready = 1'b0; run_n(2);
    check("idle_busy", busy, 1'b0);
    check("idle_mem_addr", mem_addr, 32'h0);
    check("idle_if_rdata", if_rdata, 32'h0);

    // Single fetch, k = 2
    bmem[0] = 32'h00500093; next_k = 2; vcnt = 0;
    if_req = 1'b1; if_addr = 32'h10; t = cyc;
    run_n(5);
    if_req = 1'b0; run_n(1);
    check("fetch_valid_cycles", vcnt, 3);
    check("fetch_done_cycle", last_if_done, t + 4);
    check("fetch_rdata", if_rdata, 32'h00500093);
    check("fetch_stall_at_done", if_stall_at_done, 1'b0);

    // Store then load, k = 0
    next_k = 0; vcnt = 0;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF; t = cyc;
    run_n(3);
    check("store_done_cycle", last_d_done, t + 2);
    check("store_d_rdata", d_rdata, 32'h0);
    d_we = 1'b0; d_wdata = $urandom;
    run_n(3);
    d_req = 1'b0; run_n(1);
    check("load_done_cycle", last_d_done, t + 5);
    check("load_d_rdata", d_rdata, 32'hDEADBEEF);
    check("store_load_valid_cycles", vcnt, 2);

    // Contention: data first, fetch next IDLE cycle
    if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h24; t = cyc;
    run_n(3);
    d_req = 1'b0;
    run_n(3);
    if_req = 1'b0; run_n(1);
    check("contend_d_done", last_d_done, t + 2);
    check("contend_if_done", last_if_done, t + 5);

    // Starvation: back-to-back loads while fetch waits
    obs_log.delete();
    if_req = 1'b1; if_addr = 32'h30; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h34; t = cyc;
    run_n(15);
    check("starve_log_size", obs_log.size(), 5);
    for (int i = 0; i < 4; i++) check("starve_data_grant", obs_log[i], 1'b1);
    check("starve_fetch_grant", obs_log[4], 1'b0);
    check("starve_fetch_done", last_if_done, t + 14);
    if_req = 1'b0; run_n(3);
    d_req = 1'b0; run_n(1);

    // Reset mid-access
    next_k = 3; cnt0 = if_done_cnt + d_done_cnt;
    if_req = 1'b1; if_addr = 32'h40;
    run_n(2);
    reset = 1'b1; if_req = 1'b0;
    cycle();
    reset = 1'b0; force_ready = 1'b1;
    cycle();
    force_ready = 1'b0;
    run_n(3);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_valid", mem_valid, 1'b0);
    check("rst_mid_no_done", if_done_cnt + d_done_cnt, cnt0);
    check("rst_mid_if_rdata", if_rdata, 32'h0);
    check("rst_mid_d_rdata", d_rdata, 32'h0);

    // Randomized traffic with random latency and spurious acknowledges
    next_k = -1; spurious = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (if_req && done_cyc == cyc - 1 && !exp_owner) if_req = 1'b0;
      if (d_req && done_cyc == cyc - 1 && exp_owner) d_req = 1'b0;
      if (!if_req) begin
        if_addr = $urandom;
        if ($urandom_range(0, 99) < 50) if_req = 1'b1;
      end
      if (!d_req) begin
        d_addr  = $urandom;
        d_wdata = $urandom;
        d_we    = ($urandom_range(0, 2) == 0);
        if ($urandom_range(0, 99) < 85) d_req = 1'b1;
      end
      cycle();
    end
    if_req = 1'b0; d_req = 1'b0; spurious = 1'b0;
    run_n(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
